tlul_sram_bridge: RTL and testbench

TL-UL device-side adapter that terminates one TL-UL link and drives a single-port, fixed one-cycle-latency SRAM. It sits directly downstream of the core's TL-UL host adapters, behind the crossbar or point-to-point, and serves as the instruction or data memory of the brq core. It checks each A-channel request, issues at most one SRAM access per cycle, and returns in-order D-channel responses through a small response buffer so the host can keep up to `Outstanding` requests in flight.

---
 rtl/tlul_pkg.sv | 55 +++++
 rtl/tlul_fifo_sync.sv | 50 +++++
 rtl/tlul_sram_bridge.sv | 117 +++++++++++
 tb/tb_tlul_sram_bridge.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// TL-UL bus types shared by host and device adapters, plus the response-buffer
// entry used by SRAM-style devices.
package tlul_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_DUW = 1;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic [TL_DUW-1:0] d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  typedef struct packed {
    tl_d_op_e          opcode;
    logic [TL_AIW-1:0] source;
    logic [TL_SZW-1:0] size;
    logic              error;
    logic [TL_DW-1:0]  data;
  } tl_sram_rsp_t;
endpackage

// File: rtl/tlul_fifo_sync.sv
// Synchronous FIFO of arbitrary packed type; pointers wrap modulo Depth.
module tlul_fifo_sync #(
  parameter int  Depth = 2,
  parameter type T     = logic [31:0],
  localparam int CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wvalid_i,
  input  T                wdata_i,
  input  logic            rready_i,
  output logic            rvalid_o,
  output T                rdata_o,
  output logic [CntW-1:0] count_o
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  T                mem_q [2**PtrW];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push     = wvalid_i && (count_q != CntW'(Depth));
  assign pop      = rready_i && (count_q != '0);
  assign rvalid_o = (count_q != '0);
  assign rdata_o  = mem_q[rptr_q];
  assign count_o  = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: entries are only observed once counted valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/tlul_sram_bridge.sv
// TL-UL device adapter for a one-cycle-latency single-port SRAM with an
// in-order response buffer of Outstanding entries.
module tlul_sram_bridge import tlul_pkg::*; #(
  parameter int SramAw      = 10,
  parameter int Outstanding = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tl_h2d_t           tl_i,
  output tl_d2h_t           tl_o,
  output logic              req_o,
  output logic              we_o,
  output logic [SramAw-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic [31:0]       wmask_o,
  input  logic [31:0]       rdata_i
);
  localparam int CntW = $clog2(Outstanding + 1);

  logic [CntW-1:0]   fifo_cnt;
  logic [CntW:0]     occ;
  logic              a_ready, accept, is_get, is_put, err;
  logic              inflight_q, err_q, rd_q;
  tl_d_op_e          op_q;
  logic [TL_AIW-1:0] src_q;
  logic [TL_SZW-1:0] size_q;
  tl_sram_rsp_t      push_ent, head;
  logic              d_valid;
  logic [31:0]       mask_bits;
  logic              unused_param;

  assign unused_param = ^tl_i.a_param;

  // Occupancy counts the access in flight so a full buffer is never overrun.
  assign occ     = {1'b0, fifo_cnt} + (CntW + 1)'(inflight_q);
  assign a_ready = !rst_i && (occ < (CntW + 1)'(Outstanding));
  assign accept  = tl_i.a_valid && a_ready;

  assign is_get = (tl_i.a_opcode == Get);
  assign is_put = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
  assign err    = !(is_get || is_put)
               || (tl_i.a_address[1:0] != 2'b00)
               || (tl_i.a_address[TL_AW-1:SramAw+2] != '0)
               || (tl_i.a_size > 2'd2)
               || ((tl_i.a_opcode == PutFullData) && (tl_i.a_mask != 4'hF));

  for (genvar b = 0; b < 4; b++) begin : g_mask
    assign mask_bits[8*b +: 8] = {8{tl_i.a_mask[b]}};
  end

  assign req_o   = accept && !err;
  assign we_o    = req_o && is_put;
  assign addr_o  = req_o ? tl_i.a_address[SramAw+1:2] : '0;
  assign wdata_o = we_o ? tl_i.a_data : '0;
  assign wmask_o = we_o ? mask_bits : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= 1'b0;
      op_q       <= AccessAck;
      src_q      <= '0;
      size_q     <= '0;
      err_q      <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      inflight_q <= accept;
      if (accept) begin
        if (is_get) op_q <= AccessAckData;
        else        op_q <= AccessAck;
        src_q  <= tl_i.a_source;
        size_q <= tl_i.a_size;
        err_q  <= err;
        rd_q   <= is_get;
      end
    end
  end

  always_comb begin
    push_ent        = '0;
    push_ent.opcode = op_q;
    push_ent.source = src_q;
    push_ent.size   = size_q;
    push_ent.error  = err_q;
    push_ent.data   = (rd_q && !err_q) ? rdata_i : '0;
  end

  logic fifo_rvalid;

  tlul_fifo_sync #(
    .Depth (Outstanding),
    .T     (tl_sram_rsp_t)
  ) u_rsp_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wvalid_i (inflight_q),
    .wdata_i  (push_ent),
    .rready_i (d_valid && tl_i.d_ready),
    .rvalid_o (fifo_rvalid),
    .rdata_o  (head),
    .count_o  (fifo_cnt)
  );

  assign d_valid = fifo_rvalid && !rst_i;

  always_comb begin
    tl_o         = '0;
    tl_o.a_ready = a_ready;
    tl_o.d_valid = d_valid;
    if (d_valid) begin
      tl_o.d_opcode = head.opcode;
      tl_o.d_source = head.source;
      tl_o.d_size   = head.size;
      tl_o.d_error  = head.error;
      tl_o.d_data   = head.data;
    end
  end
endmodule

// File: tb/tb_tlul_sram_bridge.sv
// Bench for tlul_sram_bridge: transaction-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_tlul_sram_bridge;
  import tlul_pkg::*;

  localparam int SramAw = 10;
  localparam int OUT    = 2;
  localparam int WORDS  = 1 << SramAw;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  tl_h2d_t           tl_i;
  tl_d2h_t           tl_o;
  logic              req, we;
  logic [SramAw-1:0] addr;
  logic [31:0]       wdata, wmask, rdata;

  always #5 clk = ~clk;

  tlul_sram_bridge #(.SramAw(SramAw), .Outstanding(OUT)) dut (
    .clk_i(clk), .rst_i(rst), .tl_i(tl_i), .tl_o(tl_o),
    .req_o(req), .we_o(we), .addr_o(addr), .wdata_o(wdata),
    .wmask_o(wmask), .rdata_i(rdata)
  );

  // SRAM environment
  logic [31:0] sram [WORDS];
  always @(posedge clk) begin
    if (req) begin
      if (we) sram[addr] <= (sram[addr] & ~wmask) | (wdata & wmask);
      else    rdata <= sram[addr];
    end
  end

  int npass = 0;
  int ntot  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Transaction model: expected memory and queues of accepted-but-unacked responses
  typedef struct {
    logic [2:0]  op;
    logic [7:0]  src;
    logic [1:0]  sz;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic [31:0] mem_m [WORDS];
  exp_t        pend[$];
  exp_t        rspq[$];
  exp_t        e;
  bit          m_rdy, m_acc, m_err, m_get, m_put;
  logic [31:0] m_mask;
  int          widx;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_a_ready", 32'(tl_o.a_ready), 32'd0);
      check("rst_d_valid", 32'(tl_o.d_valid), 32'd0);
      check("rst_req", 32'(req), 32'd0);
      check("rst_addr", 32'(addr), 32'd0);
      pend.delete();
      rspq.delete();
    end else begin
      m_rdy = (pend.size() + rspq.size()) < OUT;
      check("a_ready", 32'(tl_o.a_ready), 32'(m_rdy));
      check("d_valid", 32'(tl_o.d_valid), 32'(rspq.size() > 0));
      if (rspq.size() > 0) begin
        check("d_opcode", 32'(tl_o.d_opcode), 32'(rspq[0].op));
        check("d_source", 32'(tl_o.d_source), 32'(rspq[0].src));
        check("d_size",   32'(tl_o.d_size),   32'(rspq[0].sz));
        check("d_error",  32'(tl_o.d_error),  32'(rspq[0].err));
        check("d_data",   tl_o.d_data,        rspq[0].data);
      end
      m_acc  = tl_i.a_valid && m_rdy;
      m_get  = (tl_i.a_opcode == Get);
      m_put  = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
      m_err  = !(m_get || m_put) || (tl_i.a_address % 4 != 0)
            || (tl_i.a_address >= 32'(4 * WORDS)) || (tl_i.a_size > 2)
            || (tl_i.a_opcode == PutFullData && tl_i.a_mask != 4'hF);
      widx   = int'(tl_i.a_address / 4) % WORDS;
      m_mask = 32'h0;
      for (int b = 0; b < 4; b++) if (tl_i.a_mask[b]) m_mask = m_mask | (32'hFF << (8 * b));
      check("req", 32'(req), 32'(m_acc && !m_err));
      if (m_acc && !m_err) begin
        check("we", 32'(we), 32'(m_put));
        check("addr", 32'(addr), 32'(widx));
        if (m_put) begin
          check("wmask", wmask, m_mask);
          check("wdata", wdata, tl_i.a_data);
        end
      end
      if (rspq.size() > 0 && tl_i.d_ready) void'(rspq.pop_front());
      if (pend.size() > 0) rspq.push_back(pend.pop_front());
      if (m_acc) begin
        e.op   = m_get ? 3'd1 : 3'd0;
        e.src  = tl_i.a_source;
        e.sz   = tl_i.a_size;
        e.err  = m_err;
        e.data = (m_get && !m_err) ? mem_m[widx] : 32'h0;
        if (m_put && !m_err) mem_m[widx] = (mem_m[widx] & ~m_mask) | (tl_i.a_data & m_mask);
        pend.push_back(e);
      end
    end
  end

  // Directed drivers
  logic        acc_req, acc_we;
  logic [31:0] acc_addr, acc_wmask;
  logic [2:0]  r_op;
  logic [7:0]  r_src;
  logic        r_err;
  logic [31:0] r_data;

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [1:0] sz,
                       input logic [3:0] m, input logic [31:0] d, input logic [7:0] s);
    @(posedge clk); #1;
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = tl_a_op_e'(op);
    tl_i.a_address = a;
    tl_i.a_size    = sz;
    tl_i.a_mask    = m;
    tl_i.a_data    = d;
    tl_i.a_source  = s;
  endtask

  task automatic wait_acc();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tl_o.a_ready) begin
        acc_req = req; acc_we = we; acc_addr = 32'(addr); acc_wmask = wmask;
        @(posedge clk); #1;
        tl_i.a_valid = 1'b0;
        return;
      end
    end
    check("accept_timeout", 32'd0, 32'd1);
    tl_i.a_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tl_o.d_valid && tl_i.d_ready) begin
        r_op = 3'(tl_o.d_opcode); r_src = tl_o.d_source;
        r_err = tl_o.d_error; r_data = tl_o.d_data;
        return;
      end
    end
    check("response_timeout", 32'd0, 32'd1);
  endtask

  typedef struct { logic [2:0] op; logic [31:0] a; logic [3:0] m; } err_vec_t;
  err_vec_t evec[4];
  int       got[$];
  bit       acc_now;

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      sram[i]  = 32'h5A000000 | 32'(i);
      mem_m[i] = 32'h5A000000 | 32'(i);
    end
    rdata = '0;
    tl_i = '0;
    tl_i.d_ready = 1'b1;

    // reset / idle
    repeat (2) @(negedge clk);
    check("lit_rst_a_ready", 32'(tl_o.a_ready), 32'd0);
    check("lit_rst_d_valid", 32'(tl_o.d_valid), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("lit_ready_after_rst", 32'(tl_o.a_ready), 32'd1);

    // write then read
    drive(3'd0, 32'h10, 2'd2, 4'hF, 32'hDEADBEEF, 8'd3);
    wait_acc();
    check("lit_pf_req", 32'(acc_req), 32'd1);
    check("lit_pf_we", 32'(acc_we), 32'd1);
    check("lit_pf_addr", acc_addr, 32'd4);
    check("lit_pf_wmask", acc_wmask, 32'hFFFFFFFF);
    wait_rsp();
    check("lit_pf_op", 32'(r_op), 32'd0);
    check("lit_pf_src", 32'(r_src), 32'd3);
    check("lit_pf_err", 32'(r_err), 32'd0);
    drive(3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'd5);
    wait_acc();
    wait_rsp();
    check("lit_get_op", 32'(r_op), 32'd1);
    check("lit_get_data", r_data, 32'hDEADBEEF);

    // partial write over a preloaded word
    drive(3'd1, 32'h20, 2'd2, 4'b0010, 32'h0000AB00, 8'd6);
    wait_acc();
    check("lit_pp_wmask", acc_wmask, 32'h0000FF00);
    wait_rsp();
    drive(3'd4, 32'h20, 2'd2, 4'hF, 32'h0, 8'd6);
    wait_acc();
    wait_rsp();
    check("lit_pp_readback", r_data, 32'h5A00AB08);

    // error cases
    evec[0] = '{3'd4, 32'h1000, 4'hF};
    evec[1] = '{3'd4, 32'h2,    4'hF};
    evec[2] = '{3'd2, 32'h10,   4'hF};
    evec[3] = '{3'd0, 32'h10,   4'h3};
    foreach (evec[k]) begin
      drive(evec[k].op, evec[k].a, 2'd2, evec[k].m, 32'h12345678, 8'(10 + k));
      wait_acc();
      check($sformatf("lit_err%0d_req", k), 32'(acc_req), 32'd0);
      wait_rsp();
      check($sformatf("lit_err%0d_derr", k), 32'(r_err), 32'd1);
      if (k == 0) check("lit_err0_data", r_data, 32'h0);
    end

    // backpressure: buffer fills at two, third request held
    @(posedge clk); #1 tl_i.d_ready = 1'b0;
    drive(3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'd0); wait_acc();
    drive(3'd4, 32'h20, 2'd2, 4'hF, 32'h0, 8'd1); wait_acc();
    drive(3'd4, 32'h30, 2'd2, 4'hF, 32'h0, 8'd2);
    repeat (3) begin
      @(negedge clk);
      check("lit_full_a_ready", 32'(tl_o.a_ready), 32'd0);
      check("lit_full_req", 32'(req), 32'd0);
    end
    @(posedge clk); #1 tl_i.d_ready = 1'b1;
    for (int i = 0; i < 20 && got.size() < 3; i++) begin
      @(negedge clk);
      if (tl_o.d_valid) got.push_back(int'(tl_o.d_source));
      acc_now = tl_i.a_valid && tl_o.a_ready;
      @(posedge clk); #1;
      if (acc_now) tl_i.a_valid = 1'b0;
    end
    check("lit_drain_count", 32'(got.size()), 32'd3);
    for (int i = 0; i < got.size(); i++)
      check($sformatf("lit_drain_src%0d", i), 32'(got[i]), 32'(i));

    // reset with two responses buffered
    @(posedge clk); #1 tl_i.d_ready = 1'b0;
    drive(3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'd7); wait_acc();
    drive(3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'd8); wait_acc();
    @(posedge clk); #3;
    check("lit_pre_rst_d_valid", 32'(tl_o.d_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("lit_mid_rst_d_valid", 32'(tl_o.d_valid), 32'd0);
    check("lit_mid_rst_a_ready", 32'(tl_o.a_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    tl_i.d_ready = 1'b1;
    @(negedge clk);
    check("lit_post_rst_a_ready", 32'(tl_o.a_ready), 32'd1);
    check("lit_post_rst_d_valid", 32'(tl_o.d_valid), 32'd0);
    drive(3'd4, 32'h10, 2'd2, 4'hF, 32'h0, 8'd9);
    wait_acc();
    wait_rsp();
    check("lit_post_rst_src", 32'(r_src), 32'd9);
    check("lit_post_rst_data", r_data, 32'hDEADBEEF);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
